stereo_sound_port: RTL and testbench

Parametrised stereo sound front-end for the expansion board: it takes NCH external 8-bit sample sources (AY channels, second AY, etc.) plus an internal covox latch, and applies a per-source 2-bit pan set by CPU port writes. A time-multiplexed accumulator mixes the sources into left/right sums once per clock-enable tick, and two first-order sigma-delta modulators produce one-bit audio. It also generates the chip clock enable the sound generators use, so mixing stays phase-locked to sample updates.

---
 rtl/stereo_sound_port.sv | 173 +++++++++++++++++
 tb/tb_stereo_sound_port.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stereo_sound_port.sv
// Stereo sound front-end: pan/covox port registers, time-multiplexed L/R mixer
// locked to the generator clock enable, and first-order sigma-delta outputs.
module stereo_sound_port #(
    parameter int unsigned NCH        = 6,
    parameter int unsigned SAMPLE_W   = 8,
    parameter int unsigned CE_DIV     = 15,
    parameter logic [7:0]  COVOX_PORT = 8'h07,
    parameter logic [7:0]  PAN_BASE   = 8'h0C,
    localparam int unsigned MIX_W     = SAMPLE_W + $clog2(NCH + 1)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [7:0]                shavv,
    input  logic [7:0]                data,
    input  logic                      negedge_zpvv_n,
    input  logic                      negedge_chtvv_n,
    input  logic [NCH*SAMPLE_W-1:0]   ch_samples,
    output logic [7:0]                data_o,
    output logic                      data_oe,
    output logic                      ce_out,
    output logic [MIX_W-1:0]          mix_l,
    output logic [MIX_W-1:0]          mix_r,
    output logic                      mix_valid,
    output logic                      audio_l,
    output logic                      audio_r
);

    localparam int unsigned NSRC  = NCH + 1;
    localparam int unsigned NPAN  = (NSRC + 3) / 4;
    localparam int unsigned IDX_W = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam int unsigned CNT_W = $clog2(CE_DIV);

    typedef enum logic [1:0] {IDLE, ACC, DONE} seq_state_t;

    logic [CNT_W-1:0]    div_cnt;
    logic [SAMPLE_W-1:0] covox;
    logic [1:0]          pan      [NSRC];
    logic [SAMPLE_W-1:0] snap     [NSRC];
    logic [1:0]          snap_pan [NSRC];
    seq_state_t          state;
    logic [IDX_W-1:0]    idx;
    logic [MIX_W-1:0]    acc_l, acc_r, add_l, add_r;
    logic [MIX_W-1:0]    sd_l, sd_r;
    logic [MIX_W:0]      sum_l, sum_r;
    logic [7:0]          pan_off, rd_val;
    logic                pan_hit, covox_hit;

    // Clock-enable divider
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_cnt <= '0;
            ce_out  <= 1'b0;
        end else begin
            ce_out  <= (div_cnt == CNT_W'(CE_DIV - 1));
            div_cnt <= (div_cnt == CNT_W'(CE_DIV - 1)) ? '0 : div_cnt + CNT_W'(1);
        end
    end

    assign pan_off   = shavv - PAN_BASE;
    assign pan_hit   = (pan_off < 8'(NPAN));
    assign covox_hit = (shavv == COVOX_PORT);

    // Covox latch and pan registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            covox <= '0;
            for (int s = 0; s < int'(NSRC); s++) pan[s] <= 2'b11;
        end else if (negedge_zpvv_n) begin
            if (covox_hit) covox <= data[SAMPLE_W-1:0];
            if (pan_hit) begin
                for (int s = 0; s < int'(NSRC); s++)
                    if (pan_off == 8'(s / 4)) pan[s] <= data[(s % 4) * 2 +: 2];
            end
        end
    end

    // Read-back mux; bits of nonexistent sources stay zero
    always_comb begin
        rd_val = 8'h00;
        if (covox_hit) begin
            rd_val = 8'(covox);
        end else begin
            for (int s = 0; s < int'(NSRC); s++)
                if (pan_off == 8'(s / 4)) rd_val[(s % 4) * 2 +: 2] = pan[s];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_o  <= 8'hFF;
            data_oe <= 1'b0;
        end else begin
            data_oe <= 1'b0;
            if (negedge_chtvv_n && (covox_hit || pan_hit)) begin
                data_o  <= rd_val;
                data_oe <= 1'b1;
            end
        end
    end

    // Snapshot of sources and pans taken as the mix starts
    always_ff @(posedge clk) begin
        if (reset_n && state == IDLE && ce_out) begin
            for (int k = 0; k < int'(NCH); k++)
                snap[k] <= ch_samples[k * SAMPLE_W +: SAMPLE_W];
            snap[NCH] <= covox;
            for (int s = 0; s < int'(NSRC); s++) snap_pan[s] <= pan[s];
        end
    end

    always_comb begin
        add_l = snap_pan[idx][0] ? MIX_W'(snap[idx]) : '0;
        add_r = snap_pan[idx][1] ? MIX_W'(snap[idx]) : '0;
    end

    // Mix sequencer; the last add is folded into the output load
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            idx       <= '0;
            acc_l     <= '0;
            acc_r     <= '0;
            mix_l     <= '0;
            mix_r     <= '0;
            mix_valid <= 1'b0;
        end else begin
            mix_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (ce_out) begin
                        acc_l <= '0;
                        acc_r <= '0;
                        idx   <= '0;
                        state <= ACC;
                    end
                end
                ACC: begin
                    if (idx == IDX_W'(NCH)) begin
                        mix_l     <= acc_l + add_l;
                        mix_r     <= acc_r + add_r;
                        mix_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        acc_l <= acc_l + add_l;
                        acc_r <= acc_r + add_r;
                        idx   <= idx + IDX_W'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign sum_l = {1'b0, sd_l} + {1'b0, mix_l};
    assign sum_r = {1'b0, sd_r} + {1'b0, mix_r};

    // First-order sigma-delta: carry out of the accumulator is the bitstream
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sd_l    <= '0;
            sd_r    <= '0;
            audio_l <= 1'b0;
            audio_r <= 1'b0;
        end else begin
            sd_l    <= sum_l[MIX_W-1:0];
            sd_r    <= sum_r[MIX_W-1:0];
            audio_l <= sum_l[MIX_W];
            audio_r <= sum_r[MIX_W];
        end
    end

endmodule

// File: tb/tb_stereo_sound_port.sv
// Bench for stereo_sound_port: behavioural reference model checked every cycle
// plus directed scenarios with hand-computed expectations.
module tb_stereo_sound_port;

    localparam int unsigned NCH        = 6;
    localparam int unsigned SAMPLE_W   = 8;
    localparam int unsigned CE_DIV     = 15;
    localparam logic [7:0]  COVOX_PORT = 8'h07;
    localparam logic [7:0]  PAN_BASE   = 8'h0C;
    localparam int unsigned MIX_W      = 11;
    localparam int unsigned NPAN       = 2;
    localparam int          FULL       = 2 ** MIX_W;

    logic                    clk = 1'b0;
    logic                    reset_n;
    logic [7:0]              shavv, data;
    logic                    negedge_zpvv_n, negedge_chtvv_n;
    logic [NCH*SAMPLE_W-1:0] ch_samples;
    logic [7:0]              data_o;
    logic                    data_oe, ce_out, mix_valid, audio_l, audio_r;
    logic [MIX_W-1:0]        mix_l, mix_r;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stereo_sound_port #(
        .NCH(NCH), .SAMPLE_W(SAMPLE_W), .CE_DIV(CE_DIV),
        .COVOX_PORT(COVOX_PORT), .PAN_BASE(PAN_BASE)
    ) dut (
        .clk(clk), .reset_n(reset_n), .shavv(shavv), .data(data),
        .negedge_zpvv_n(negedge_zpvv_n), .negedge_chtvv_n(negedge_chtvv_n),
        .ch_samples(ch_samples), .data_o(data_o), .data_oe(data_oe),
        .ce_out(ce_out), .mix_l(mix_l), .mix_r(mix_r), .mix_valid(mix_valid),
        .audio_l(audio_l), .audio_r(audio_r)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    int         rel_cnt, m_mix_l, m_mix_r, m_sd_l, m_sd_r, pend_due, pend_l, pend_r;
    bit         m_ce, m_valid, m_oe, m_aud_l, m_aud_r, pend;
    logic [7:0] m_data_o, m_covox;
    logic [1:0] m_pan [0:NCH];

    function automatic bit owned(input logic [7:0] a);
        logic [7:0] off;
        off = a - PAN_BASE;
        return (a == COVOX_PORT) || (off < NPAN);
    endfunction

    function automatic logic [7:0] reg_val(input logic [7:0] a);
        logic [7:0] v;
        logic [7:0] off;
        int p;
        v = 8'h00;
        if (a == COVOX_PORT) return m_covox;
        off = a - PAN_BASE;
        p = int'(off);
        for (int j = 0; j < 4; j++)
            if (4 * p + j <= int'(NCH)) v[2*j +: 2] = m_pan[4 * p + j];
        return v;
    endfunction

    always @(posedge clk) begin
        int s_l, s_r, l, r, v, p;
        logic [7:0] off;
        if (!reset_n) begin
            rel_cnt = 0; m_ce = 0; m_valid = 0; pend = 0;
            m_mix_l = 0; m_mix_r = 0; m_sd_l = 0; m_sd_r = 0;
            m_aud_l = 0; m_aud_r = 0; m_data_o = 8'hFF; m_oe = 0;
            m_covox = 8'h00;
            for (int s = 0; s <= int'(NCH); s++) m_pan[s] = 2'b11;
        end else begin
            s_l = m_sd_l + m_mix_l;
            s_r = m_sd_r + m_mix_r;
            m_aud_l = (s_l >= FULL);
            m_aud_r = (s_r >= FULL);
            m_sd_l = s_l % FULL;
            m_sd_r = s_r % FULL;
            m_valid = 0;
            if (pend && pend_due == rel_cnt + 1) begin
                m_mix_l = pend_l; m_mix_r = pend_r; m_valid = 1; pend = 0;
            end
            if (m_ce) begin
                l = 0; r = 0;
                for (int s = 0; s <= int'(NCH); s++) begin
                    v = (s < int'(NCH)) ? int'(ch_samples[s*SAMPLE_W +: SAMPLE_W]) : int'(m_covox);
                    if (m_pan[s][0]) l += v;
                    if (m_pan[s][1]) r += v;
                end
                pend_l = l; pend_r = r; pend_due = rel_cnt + int'(NCH) + 2; pend = 1;
            end
            m_oe = 0;
            if (negedge_chtvv_n && owned(shavv)) begin
                m_data_o = reg_val(shavv);
                m_oe = 1;
            end
            if (negedge_zpvv_n && owned(shavv)) begin
                if (shavv == COVOX_PORT) begin
                    m_covox = data;
                end else begin
                    off = shavv - PAN_BASE;
                    p = int'(off);
                    for (int j = 0; j < 4; j++)
                        if (4 * p + j <= int'(NCH)) m_pan[4 * p + j] = data[2*j +: 2];
                end
            end
            rel_cnt++;
            m_ce = (rel_cnt % CE_DIV) == 0;
        end
        #1;
        chk("ce_out", ce_out, m_ce);
        chk("mix_valid", mix_valid, m_valid);
        chk("mix_l", mix_l, m_mix_l);
        chk("mix_r", mix_r, m_mix_r);
        chk("data_o", data_o, m_data_o);
        chk("data_oe", data_oe, m_oe);
        chk("audio_l", audio_l, m_aud_l);
        chk("audio_r", audio_r, m_aud_r);
    end

    task automatic wait_ce(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (ce_out) begin n = i; break; end
        end
        if (n < 0) begin
            checks++; errors++;
            $display("FAIL wait_ce timed out at %0t", $time);
        end
    endtask

    task automatic wait_valid(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (mix_valid) begin n = i; break; end
        end
        if (n < 0) begin
            checks++; errors++;
            $display("FAIL wait_valid timed out at %0t", $time);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        shavv = a; data = d; negedge_zpvv_n = 1'b1;
        @(negedge clk);
        negedge_zpvv_n = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a);
        @(negedge clk);
        shavv = a; negedge_chtvv_n = 1'b1;
        @(negedge clk);
        negedge_chtvv_n = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        int k, n, cnt;
        logic [7:0] ports [6];
        ports = '{8'h07, 8'h0C, 8'h0D, 8'h0E, 8'h14, 8'h0B};
        reset_n = 1'b0; shavv = 8'h00; data = 8'h00;
        negedge_zpvv_n = 1'b0; negedge_chtvv_n = 1'b0; ch_samples = '0;
        repeat (3) @(negedge clk);
        chk("rst_data_o", data_o, 8'hFF);
        chk("rst_ce_out", ce_out, 0);
        chk("rst_mix_l", mix_l, 0);

        // Cadence from release
        reset_n = 1'b1;
        wait_ce(k);    chk("first_ce_cycle", k, 15);
        wait_valid(k); chk("ce_to_valid", k, 8);
        wait_ce(k);    chk("valid_to_next_ce", k, 7);
        wait_ce(k);    chk("ce_period", k, 15);

        // Full scale
        ch_samples = '1;
        wr(COVOX_PORT, 8'hFF);
        wait_valid(k); wait_valid(k);
        chk("full_mix_l", mix_l, 1785);
        chk("full_mix_r", mix_r, 1785);
        cnt = 0;
        repeat (2 * FULL) begin
            @(negedge clk);
            cnt += int'(audio_l);
        end
        chk("audio_l_density", cnt, 1785 * 2);

        // Pan codes
        wr(PAN_BASE, 8'h27);
        wr(COVOX_PORT, 8'h00);
        ch_samples = '0;
        ch_samples[7:0] = 8'd10; ch_samples[15:8] = 8'd20; ch_samples[23:16] = 8'd30;
        wait_valid(k); wait_valid(k);
        chk("pan_mix_l", mix_l, 30);
        chk("pan_mix_r", mix_r, 40);
        rd(PAN_BASE);
        chk("pan_read", data_o, 8'h27);
        chk("pan_read_oe", data_oe, 1);
        @(negedge clk);
        chk("pan_read_oe_drop", data_oe, 0);

        // Covox write in the ce cycle, with simultaneous read
        wait_ce(k);
        shavv = COVOX_PORT; data = 8'h80; negedge_zpvv_n = 1'b1; negedge_chtvv_n = 1'b1;
        @(negedge clk);
        negedge_zpvv_n = 1'b0; negedge_chtvv_n = 1'b0;
        chk("rw_old_value", data_o, 0);
        chk("rw_oe", data_oe, 1);
        wait_valid(k);
        chk("covox_excluded_l", mix_l, 30);
        wait_valid(k);
        chk("covox_included_l", mix_l, 158);
        chk("covox_included_r", mix_r, 168);

        // Partial pan port and unowned port
        wr(8'(PAN_BASE + 8'd1), 8'hFF);
        rd(8'(PAN_BASE + 8'd1));
        chk("pan1_read", data_o, 8'h3F);
        rd(8'h14);
        chk("unowned_oe", data_oe, 0);
        chk("unowned_data", data_o, 8'h3F);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            ch_samples = {$urandom, $urandom};
            shavv = ports[$urandom_range(0, 5)];
            data = 8'($urandom);
            negedge_zpvv_n = ($urandom_range(0, 3) == 0);
            negedge_chtvv_n = ($urandom_range(0, 3) == 0);
        end
        @(negedge clk);
        negedge_zpvv_n = 1'b0; negedge_chtvv_n = 1'b0;

        // Reset in the middle of a mix
        wait_ce(k);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("abort_mix_l", mix_l, 0);
        chk("abort_mix_valid", mix_valid, 0);
        chk("abort_data_o", data_o, 8'hFF);
        chk("abort_audio_l", audio_l, 0);
        reset_n = 1'b1;
        cnt = 0; n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            cnt += int'(mix_valid);
            if (ce_out) begin n = i; break; end
        end
        chk("ce_after_abort", n, 15);
        chk("no_valid_after_abort", cnt, 0);
        wait_valid(k);
        chk("valid_after_abort", k, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
